// File: rtl/nec_prefetch_pkg.sv
// Shared types for the nec_prefetch instruction queue.
// Build option: define NEC_PREFETCH_WORD_EN for a 16-bit fetch bus; the default
// build uses an 8-bit bus that fetches one byte per acknowledge.
package nec_prefetch_pkg;

  localparam int unsigned IPQ_DEPTH = 8;

`ifdef NEC_PREFETCH_WORD_EN
  localparam bit WordFetch = 1'b1;
`else
  localparam bit WordFetch = 1'b0;
`endif

  typedef enum logic [1:0] {
    StHalt,
    StIdle,
    StReq,
    StDiscard
  } prefetch_state_e;

endpackage

// File: rtl/nec_prefetch.sv
// nec_prefetch: 8-byte address-indexed prefetch window for nec_decode.
// Fetches code bytes over a single-outstanding req/ack bus and reports how many
// bytes are valid from the decoder's pc. Bus width is set by NEC_PREFETCH_WORD_EN
// (defined: 16-bit word fetches, undefined: 8-bit byte fetches).
module nec_prefetch
  import nec_prefetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce,
  input  logic [15:0]     pc,
  input  logic            flush,
  input  logic [15:0]     flush_pc,
  output logic [7:0][7:0] ipq,
  output logic [3:0]      ipq_len,
  output logic            bus_req,
  output logic [15:0]     bus_addr,
  input  logic            bus_ack,
  input  logic [15:0]     bus_data
);

  prefetch_state_e state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic            bus_req_q, bus_req_d;
  logic [15:0]     bus_addr_q, bus_addr_d;
  logic [7:0][7:0] ipq_q, ipq_d;

  logic [15:0] fill_now, fill_acked, fetch_pc_acked;
  logic [3:0]  free_now, need_now, len_acked, free_acked, need_acked;
  logic [2:0]  wr_idx, wr_idx_hi;
  logic        ack_take;
  logic        unused_fill_hi;

  // Word-aligned fetch address on the 16-bit bus, byte address on the 8-bit bus.
  function automatic logic [15:0] fetch_addr(input logic [15:0] a);
    return WordFetch ? {a[15:1], 1'b0} : a;
  endfunction

  // Occupancy now and as it would be after taking the current acknowledge.
  always_comb begin
    fill_now       = fetch_pc_q - pc;
    ipq_len        = (state_q == StHalt) ? 4'd0 : fill_now[3:0];
    free_now       = 4'(IPQ_DEPTH) - ipq_len;
    // An odd fetch_pc only yields the high byte of its word.
    need_now       = (WordFetch && !fetch_pc_q[0]) ? 4'd2 : 4'd1;
    fetch_pc_acked = fetch_pc_q + 16'(need_now);
    fill_acked     = fetch_pc_acked - pc;
    len_acked      = fill_acked[3:0];
    free_acked     = 4'(IPQ_DEPTH) - len_acked;
    need_acked     = (WordFetch && !fetch_pc_acked[0]) ? 4'd2 : 4'd1;
  end

  // The window never exceeds 8 bytes, so only the low nibble of the distance matters.
  assign unused_fill_hi = ^{fill_now[15:4], fill_acked[15:4]};

  assign wr_idx    = fetch_pc_q[2:0];
  assign wr_idx_hi = wr_idx + 3'd1;
  // Flush wins over a coincident ack: that data is dropped.
  assign ack_take  = (state_q == StReq) && bus_ack && !flush;

  // Byte write decoder into the window.
  always_comb begin
    ipq_d = ipq_q;
    if (ack_take) begin
      if (!WordFetch) begin
        ipq_d[wr_idx] = bus_data[7:0];
      end else if (fetch_pc_q[0]) begin
        ipq_d[wr_idx] = bus_data[15:8];
      end else begin
        ipq_d[wr_idx]    = bus_data[7:0];
        ipq_d[wr_idx_hi] = bus_data[15:8];
      end
    end
  end

  // Fetch sequencing: next state, fetch pointer and bus request.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    if (flush) begin
      fetch_pc_d = flush_pc;
    end
    case (state_q)
      StHalt: begin
        if (flush) state_d = StIdle;
      end
      StIdle: begin
        if (!flush && free_now >= need_now) begin
          bus_req_d  = 1'b1;
          bus_addr_d = fetch_addr(fetch_pc_q);
          state_d    = StReq;
        end
      end
      StReq: begin
        if (flush) begin
          // A fetch cannot be aborted: keep requesting and drop its data later.
          if (bus_ack) begin
            bus_req_d = 1'b0;
            state_d   = StIdle;
          end else begin
            state_d = StDiscard;
          end
        end else if (bus_ack) begin
          fetch_pc_d = fetch_pc_acked;
          if (free_acked >= need_acked) begin
            bus_addr_d = fetch_addr(fetch_pc_acked);
          end else begin
            bus_req_d = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      StDiscard: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d   = StHalt;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State registers, advanced only on enabled edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StHalt;
      fetch_pc_q <= 16'h0000;
      bus_req_q  <= 1'b0;
      bus_addr_q <= 16'h0000;
      ipq_q      <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      ipq_q      <= ipq_d;
    end
  end

  assign ipq      = ipq_q;
  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;

endmodule
